// File: rtl/pipe_pkg.sv
// Shared definitions for the core's pipeline-stage registers.
//   - occupancy state encoding used by pipe_stage_reg
//   - per-stage data/control bundle widths
//   - per-stage "no side effect" control encodings used for bubbles
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    // IF/ID: pc + raw instruction
    localparam int IF_ID_DATA_W  = 96;
    localparam int IF_ID_CTRL_W  = 4;
    // ID/EX: pc, rs1, rs2, imm, rd
    localparam int ID_EX_DATA_W  = 64 * 4 + 5;
    localparam int ID_EX_CTRL_W  = 12;
    // EX/MEM: alu result, store data, rd
    localparam int EX_MEM_DATA_W = 64 * 2 + 5;
    localparam int EX_MEM_CTRL_W = 8;
    // MEM/WB: writeback value, rd
    localparam int MEM_WB_DATA_W = 64 + 5;
    localparam int MEM_WB_CTRL_W = 4;

    // All control bits deasserted means no register write, no memory
    // access and no branch, so zero is a safe bubble in every stage.
    localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_CTRL_NOP  = '0;
    localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_CTRL_NOP  = '0;
    localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_CTRL_NOP = '0;
    localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_CTRL_NOP = '0;

    // True when the stage cannot take another entry.
    function automatic logic state_is_full(input pipe_state_e s);
        return s == PS_FULL;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream carrying one data bundle and one control bundle.
//   valid : producer holds a valid entry
//   ready : consumer accepts this cycle
//   data  : data bundle
//   ctrl  : control bundle
// master = producer side, slave = consumer side.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 12
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );

endinterface

// File: rtl/pipe_skid_slot.sv
// One storage entry of a pipeline stage: valid flag + data + control.
//   clk, rst       : clock, synchronous active-high reset
//   load           : capture d_data/d_ctrl and mark valid
//   clear          : drop the entry (ctrl forced to CTRL_NOP, data held)
//   d_data, d_ctrl : value to load
//   valid, data, ctrl : stored entry
// clear has priority over load so a flush always wins.
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 12,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_NOP;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with optional skid entry, flush and
// bubble counter.
//   clk_PR, rst_PR : clock, synchronous active-high reset
//   up             : upstream stream (slave)   - in_valid/in_ready/data_in/ctrl_in
//   dn             : downstream stream (master) - out_valid/out_ready/data_out/ctrl_out
//   flush          : kill held and incoming entries
//   clr_cnt        : synchronous clear of bubble_cnt
//   bubble_cnt     : saturating count of cycles with out_valid=0 && out_ready=1
//
// state    | meaning
// ---------+-----------------------------------------------
// PS_EMPTY | main slot empty, output shows CTRL_NOP
// PS_ONE   | main slot valid, skid slot empty
// PS_FULL  | main and skid both valid, in_ready low (SKID=1 only)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                CTRL_W   = 12,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = 16
) (
    input  logic             clk_PR,
    input  logic             rst_PR,
    pipe_stage_reg_if.slave  up,
    pipe_stage_reg_if.master dn,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_state_e       state_q;
    pipe_state_e       state_nxt;
    logic              in_ready_q;
    logic              in_ready;
    logic              in_xfer;
    logic              out_xfer;

    logic              main_load;
    logic              main_clr;
    logic              main_from_skid;
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;

    logic              skid_load;
    logic              skid_clr;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // With a skid entry, in_ready comes from a flop so out_ready never
    // reaches upstream combinationally. flush forces acceptance so the
    // incoming entry is swallowed rather than left stuck upstream.
    assign in_ready = flush | ((SKID != 0) ? in_ready_q : (~main_valid | dn.ready));
    assign up.ready = in_ready;
    assign in_xfer  = up.valid && in_ready;
    assign out_xfer = main_valid && dn.ready;

    assign main_d_data = main_from_skid ? skid_data : up.data;
    assign main_d_ctrl = main_from_skid ? skid_ctrl : up.ctrl;

    assign dn.valid = main_valid;
    assign dn.data  = main_data;
    assign dn.ctrl  = main_ctrl;

    always_ff @(posedge clk_PR) begin
        if (rst_PR) begin
            state_q    <= PS_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= !state_is_full(state_nxt);
        end
    end

    always_comb begin
        state_nxt      = state_q;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            state_nxt = PS_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_nxt = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (in_xfer && (SKID != 0)) begin
                        skid_load = 1'b1;
                        state_nxt = PS_FULL;
                    end else if (out_xfer) begin
                        main_clr  = 1'b1;
                        state_nxt = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (out_xfer && skid_valid) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_nxt      = PS_ONE;
                    end
                end
                default: begin
                    state_nxt = PS_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    pipe_skid_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_NOP(CTRL_NOP)
    ) u_main (
        .clk   (clk_PR),
        .rst   (rst_PR),
        .load  (main_load),
        .clear (main_clr),
        .d_data(main_d_data),
        .d_ctrl(main_d_ctrl),
        .valid (main_valid),
        .data  (main_data),
        .ctrl  (main_ctrl)
    );

    // With SKID=0 skid_load is never raised, so this entry stays empty
    // and is trimmed away in synthesis.
    pipe_skid_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_NOP(CTRL_NOP)
    ) u_skid (
        .clk   (clk_PR),
        .rst   (rst_PR),
        .load  (skid_load),
        .clear (skid_clr),
        .d_data(up.data),
        .d_ctrl(up.ctrl),
        .valid (skid_valid),
        .data  (skid_data),
        .ctrl  (skid_ctrl)
    );

    always_ff @(posedge clk_PR) begin
        if (rst_PR) begin
            bubble_cnt <= '0;
        end else if (clr_cnt) begin
            bubble_cnt <= '0;
        end else if (!main_valid && dn.ready && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam logic [3:0] NOP = 4'h5;

    bit   clk = 1'b0;
    logic rst;
    logic a_flush, a_clr, b_flush, b_clr;
    logic [2:0] a_cnt, b_cnt;

    int checks   = 0;
    int failures = 0;

    logic [19:0] ref_q[$];

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(4)) ua ();
    pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(4)) da ();
    pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(4)) ub ();
    pipe_stage_reg_if #(.DATA_W(16), .CTRL_W(4)) db ();

    pipe_stage_reg #(
        .DATA_W(16), .CTRL_W(4), .CTRL_NOP(NOP), .SKID(1), .CNT_W(3)
    ) dut_a (
        .clk_PR(clk), .rst_PR(rst), .up(ua), .dn(da),
        .flush(a_flush), .clr_cnt(a_clr), .bubble_cnt(a_cnt)
    );

    pipe_stage_reg #(
        .DATA_W(16), .CTRL_W(4), .CTRL_NOP(NOP), .SKID(0), .CNT_W(3)
    ) dut_b (
        .clk_PR(clk), .rst_PR(rst), .up(ub), .dn(db),
        .flush(b_flush), .clr_cnt(b_clr), .bubble_cnt(b_cnt)
    );

    function automatic logic [3:0] ctrl_of(input logic [15:0] d);
        return {2'b11, d[1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference queue for dut_a: every accepted entry must come out once, in order.
    always @(negedge clk) begin
        logic [19:0] e;
        if (!rst) begin
            if (!da.valid) chk("a_idle_ctrl_nop", 32'(da.ctrl), 32'(NOP));
            if (da.valid && da.ready) begin
                if (ref_q.size() == 0) begin
                    chk("a_unexpected_out", 32'(da.data), 32'hFFFF_FFFF);
                end else begin
                    e = ref_q.pop_front();
                    chk("a_out_data", 32'(da.data), 32'(e[15:0]));
                    chk("a_out_ctrl", 32'(da.ctrl), 32'(e[19:16]));
                end
            end
            if (a_flush) ref_q.delete();
            else if (ua.valid && ua.ready) ref_q.push_back({ua.ctrl, ua.data});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // 1. reset held two cycles with in_valid=1
        rst = 1'b1;
        a_flush = 1'b0; a_clr = 1'b0; b_flush = 1'b0; b_clr = 1'b0;
        ua.valid = 1'b1; ua.data = 16'h0011; ua.ctrl = 4'hC; da.ready = 1'b1;
        ub.valid = 1'b1; ub.data = 16'h0022; ub.ctrl = 4'hD; db.ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; ua.valid = 1'b0; ub.valid = 1'b0;
        #1;
        chk("rst_a_out_valid", 32'(da.valid), 0);
        chk("rst_a_ctrl_nop",  32'(da.ctrl), 32'(NOP));
        chk("rst_a_data",      32'(da.data), 0);
        chk("rst_a_cnt",       32'(a_cnt), 0);
        chk("rst_a_in_ready",  32'(ua.ready), 1);
        chk("rst_b_out_valid", 32'(db.valid), 0);
        chk("rst_b_ctrl_nop",  32'(db.ctrl), 32'(NOP));
        chk("rst_b_in_ready",  32'(ub.ready), 1);

        // 2. streaming 1..8 with out_ready=1
        for (int i = 1; i <= 8; i++) begin
            tick();
            ua.valid = 1'b1; ua.data = 16'(i); ua.ctrl = ctrl_of(16'(i));
            #1;
            chk("stream_in_ready", 32'(ua.ready), 1);
            if (i > 1) begin
                chk("stream_valid", 32'(da.valid), 1);
                chk("stream_data",  32'(da.data), 32'(i - 1));
            end
        end
        tick();
        ua.valid = 1'b0;
        #1;
        chk("stream_last_data", 32'(da.data), 8);
        chk("stream_last_ctrl", 32'(da.ctrl), 32'(ctrl_of(16'd8)));
        tick();
        #1;
        chk("stream_drained", 32'(da.valid), 0);

        // 3. stall into skid: A, B pushed, C held upstream
        tick();
        ua.valid = 1'b1; ua.data = 16'h0A0A; ua.ctrl = ctrl_of(16'h0A0A); da.ready = 1'b1;
        tick();
        ua.data = 16'h0B0B; ua.ctrl = ctrl_of(16'h0B0B); da.ready = 1'b0;
        #1;
        chk("skid_ready_one", 32'(ua.ready), 1);
        chk("skid_data_a",    32'(da.data), 32'h0A0A);
        tick();
        ua.data = 16'h0C0C; ua.ctrl = ctrl_of(16'h0C0C);
        #1;
        chk("skid_full_ready", 32'(ua.ready), 0);
        chk("skid_full_valid", 32'(da.valid), 1);
        chk("skid_stall_a1",   32'(da.data), 32'h0A0A);
        tick();
        #1;
        chk("skid_stall_ready", 32'(ua.ready), 0);
        chk("skid_stall_a2",    32'(da.data), 32'h0A0A);
        tick();
        da.ready = 1'b1;
        #1;
        chk("skid_release_ready", 32'(ua.ready), 0);
        chk("skid_release_a",     32'(da.data), 32'h0A0A);
        tick();
        #1;
        chk("skid_out_b",       32'(da.data), 32'h0B0B);
        chk("skid_ready_again", 32'(ua.ready), 1);
        tick();
        ua.valid = 1'b0;
        #1;
        chk("skid_out_c",       32'(da.data), 32'h0C0C);
        chk("skid_out_c_valid", 32'(da.valid), 1);
        tick();
        #1;
        chk("skid_empty", 32'(da.valid), 0);

        // 4. flush while FULL with D offered
        tick();
        ua.valid = 1'b1; ua.data = 16'h0E0E; ua.ctrl = ctrl_of(16'h0E0E); da.ready = 1'b0;
        tick();
        ua.data = 16'h0F0F; ua.ctrl = ctrl_of(16'h0F0F);
        #1;
        chk("flush_fill_ready", 32'(ua.ready), 1);
        tick();
        ua.data = 16'h0D0D; ua.ctrl = ctrl_of(16'h0D0D); a_flush = 1'b1;
        #1;
        chk("flush_in_ready",  32'(ua.ready), 1);
        chk("flush_was_valid", 32'(da.valid), 1);
        tick();
        a_flush = 1'b0; ua.valid = 1'b0; da.ready = 1'b1;
        #1;
        chk("flush_out_valid", 32'(da.valid), 0);
        chk("flush_ctrl_nop",  32'(da.ctrl), 32'(NOP));
        chk("flush_in_ready_after", 32'(ua.ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("flush_d_absent", 32'(da.valid), 0);
        end

        // 5. bubble counter, CNT_W=3
        tick();
        a_clr = 1'b1; da.ready = 1'b1; ua.valid = 1'b0;
        tick();
        a_clr = 1'b0; da.ready = 1'b0;
        #1;
        chk("cnt_clr_over_bubble", 32'(a_cnt), 0);
        tick();
        #1;
        chk("cnt_no_ready_hold", 32'(a_cnt), 0);
        da.ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            #1;
            chk("cnt_count", 32'(a_cnt), 32'((i > 7) ? 7 : i));
        end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        #1;
        chk("cnt_clr_at_sat", 32'(a_cnt), 0);

        // 6. SKID=0 build: stream then stall
        for (int i = 1; i <= 4; i++) begin
            tick();
            ub.valid = 1'b1; ub.data = 16'(32'h100 + i); ub.ctrl = ctrl_of(16'(i)); db.ready = 1'b1;
            #1;
            chk("b_stream_ready", 32'(ub.ready), 1);
            if (i > 1) chk("b_stream_data", 32'(db.data), 32'(32'h100 + i - 1));
        end
        tick();
        ub.valid = 1'b1; ub.data = 16'h01AA; ub.ctrl = 4'hE; db.ready = 1'b0;
        #1;
        chk("b_stall_ready",  32'(ub.ready), 0);
        chk("b_stall_data",   32'(db.data), 32'h0104);
        db.ready = 1'b1;
        #1;
        chk("b_ready_follows", 32'(ub.ready), 1);
        tick();
        ub.valid = 1'b0; db.ready = 1'b0;
        #1;
        chk("b_out_x",       32'(db.data), 32'h01AA);
        chk("b_out_x_ctrl",  32'(db.ctrl), 32'hE);
        chk("b_held_ready",  32'(ub.ready), 0);
        tick();
        #1;
        chk("b_stall_stable", 32'(db.data), 32'h01AA);
        db.ready = 1'b1;
        #1;
        chk("b_release_ready", 32'(ub.ready), 1);
        tick();
        #1;
        chk("b_empty_valid", 32'(db.valid), 0);
        chk("b_empty_ctrl",  32'(db.ctrl), 32'(NOP));
        chk("b_empty_ready", 32'(ub.ready), 1);

        chk("a_ref_q_drained", 32'(ref_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
